// File: rtl/token_scanner.sv
// Lexer between the calculator token ROM and the evaluator: folds digit runs into operands
// and streams operand/operator/end tokens. Optional unary minus via TOKEN_SCANNER_NEG_EN.
module token_scanner #(
  parameter int WIDTH     = 16,
  parameter int MAX_INDEX = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [6:0]       index,
  input  logic [7:0]       rom_data,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [1:0]       tok_kind,
  output logic [WIDTH-1:0] tok_value,
  output logic [1:0]       tok_op,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, EMIT_NUM, EMIT_OP, EMIT_END, DONE, ERROR
  } state_t;

  state_t           state_reg, state_next;
  logic [6:0]       index_reg, index_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [6:0]       ndig_reg, ndig_next;
  logic             neg_reg, neg_next;
  logic             end_pend_reg, end_pend_next;
  logic             tok_valid_reg, tok_valid_next;
  logic [1:0]       tok_kind_reg, tok_kind_next;
  logic [WIDTH-1:0] tok_value_reg, tok_value_next;
  logic [1:0]       tok_op_reg, tok_op_next;

  logic             is_digit, is_end, is_op;
  logic [WIDTH+3:0] acc_prod;
  logic             acc_ovf;

  assign is_digit = (rom_data < 8'd10);
  assign is_end   = (rom_data == 8'd10);
  assign is_op    = (rom_data[7:2] == 6'd5);

  // Four guard bits hold acc*10+9 for any acc below 2^WIDTH.
  assign acc_prod = (WIDTH+4)'(acc_reg) * (WIDTH+4)'(10) + (WIDTH+4)'(rom_data[3:0]);
  assign acc_ovf  = |acc_prod[WIDTH+3:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      acc_reg       <= '0;
      ndig_reg      <= '0;
      neg_reg       <= 1'b0;
      end_pend_reg  <= 1'b0;
      tok_valid_reg <= 1'b0;
      tok_kind_reg  <= '0;
      tok_value_reg <= '0;
      tok_op_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      acc_reg       <= acc_next;
      ndig_reg      <= ndig_next;
      neg_reg       <= neg_next;
      end_pend_reg  <= end_pend_next;
      tok_valid_reg <= tok_valid_next;
      tok_kind_reg  <= tok_kind_next;
      tok_value_reg <= tok_value_next;
      tok_op_reg    <= tok_op_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    acc_next       = acc_reg;
    ndig_next      = ndig_reg;
    neg_next       = neg_reg;
    end_pend_next  = end_pend_reg;
    tok_valid_next = tok_valid_reg;
    tok_kind_next  = tok_kind_reg;
    tok_value_next = tok_value_reg;
    tok_op_next    = tok_op_reg;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_next = FETCH;
          index_next = '0;
          acc_next   = '0;
          ndig_next  = '0;
          neg_next   = 1'b0;
        end
      end

      FETCH: begin
        // Running off the end of the ROM without a terminator is malformed input.
        if (int'(index_reg) > MAX_INDEX) begin
          state_next = ERROR;
        end else if (is_digit) begin
          if (acc_ovf) begin
            state_next = ERROR;
          end else begin
            acc_next   = acc_prod[WIDTH-1:0];
            ndig_next  = ndig_reg + 7'd1;
            index_next = index_reg + 7'd1;
          end
        end else if ((is_op || is_end) && (ndig_reg != '0)) begin
          state_next     = EMIT_NUM;
          end_pend_next  = is_end;
          tok_valid_next = 1'b1;
          tok_kind_next  = 2'd0;
          tok_value_next = neg_reg ? (-acc_reg) : acc_reg;
          if (is_op) begin
            tok_op_next = rom_data[1:0];
          end
`ifdef TOKEN_SCANNER_NEG_EN
        end else if ((rom_data == 8'd21) && !neg_reg) begin
          neg_next   = 1'b1;
          index_next = index_reg + 7'd1;
`endif
        end else begin
          state_next = ERROR;
        end
      end

      EMIT_NUM: begin
        // Valid stays high so the operator/end token follows without a bubble.
        if (tok_ready) begin
          acc_next      = '0;
          ndig_next     = '0;
          neg_next      = 1'b0;
          tok_kind_next = end_pend_reg ? 2'd2 : 2'd1;
          state_next    = end_pend_reg ? EMIT_END : EMIT_OP;
        end
      end

      EMIT_OP: begin
        if (tok_ready) begin
          tok_valid_next = 1'b0;
          index_next     = index_reg + 7'd1;
          state_next     = FETCH;
        end
      end

      EMIT_END: begin
        if (tok_ready) begin
          tok_valid_next = 1'b0;
          state_next     = DONE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign index     = index_reg;
  assign tok_valid = tok_valid_reg;
  assign tok_kind  = tok_kind_reg;
  assign tok_value = tok_value_reg;
  assign tok_op    = tok_op_reg;
  assign busy      = !((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
  assign done      = (state_reg == DONE);
  assign err       = (state_reg == ERROR);

endmodule

// File: doc/token_scanner.md
# token_scanner

Lexer stage between the calculator's token ROM and the expression evaluator. On `start` it walks the ROM from index 0 and reads one 8-bit code per cycle. It folds runs of decimal digits into binary operands and emits a stream of operand, operator and end tokens over a valid/ready handshake. Malformed input stops the scan with a sticky error flag.

## Interface
- `WIDTH`, 16: operand width in bits, unsigned magnitude.
- `MAX_INDEX`, 99: last legal ROM address.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a scan; sampled only in IDLE, DONE or ERROR.
- `index` out 7: ROM address, registered.
- `rom_data` in 8: ROM code at `index`, combinational, same-cycle.
- `tok_valid` out 1: token presented.
- `tok_ready` in 1: consumer accepts the token when `tok_valid & tok_ready`.
- `tok_kind` out 2: token kind; 0 = operand, 1 = operator, 2 = end.
- `tok_value` out WIDTH: operand value, two's complement when negated.
- `tok_op` out 2: operator; 0 = `+`, 1 = `-`, 2 = `*`, 3 = `/`.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: high in DONE.
- `err` out 1: high in ERROR.

## Operation
- Codes: 0–9 are digits; 10 is `#` (end); 20/21/22/23 are `+`/`-`/`*`/`/`; any other code is an error.
- States: IDLE, FETCH, EMIT_NUM, EMIT_OP, EMIT_END, DONE, ERROR.
- IDLE/DONE/ERROR + `start` → FETCH. The same cycle clears `index`, `acc`, `ndig`, `neg`, `done` and `err`.
- FETCH, digit d: `acc <= acc*10 + d`, `ndig++`, `index++`. If the result would exceed 2^WIDTH−1 → ERROR.
- FETCH, operator:
  - `ndig==0` → ERROR (leading or doubled operator).
  - Otherwise latch the op → EMIT_NUM, then EMIT_OP.
- FETCH, `#`:
  - `ndig==0` → ERROR.
  - Otherwise → EMIT_NUM, then EMIT_END.
- FETCH with `index > MAX_INDEX` (no `#` found) → ERROR.
- EMIT_NUM: `tok_kind=0`, `tok_value=acc` (negated if `neg`). On accept, clear `acc`/`ndig`/`neg` and go to the pending EMIT_OP or EMIT_END.
- EMIT_OP: `tok_kind=1`. On accept, `index++` → FETCH.
- EMIT_END: `tok_kind=2`. On accept → DONE.
- Leading zeros are legal: "0","5" gives 5.
- Reset values: `index=0`, `tok_valid=0`, `tok_kind=0`, `tok_value=0`, `tok_op=0`, `busy=0`, `done=0`, `err=0`, state IDLE.

## Timing
- `start` at edge N → FETCH with `index=0` after N. One code is consumed per FETCH cycle.
- A k-digit operand followed by an operator costs k FETCH cycles, then 1 EMIT_NUM cycle and 1 EMIT_OP cycle, each extended by `tok_ready` wait cycles.
- `tok_valid` is registered. While `tok_valid=1` and `tok_ready=0`, `tok_kind`, `tok_value`, `tok_op` and `index` hold stable.
- `tok_valid` drops in the cycle after accept unless the next state emits again. EMIT_NUM→EMIT_OP is back-to-back, with no bubble.
- `start` while `busy` is ignored.
- `rst` mid-scan → IDLE immediately. Any pending token is dropped and `tok_valid` falls asynchronously.
- ERROR and DONE hold until `start` or `rst`. `tok_valid=0` in both.

## Configuration
- `TOKEN_SCANNER_NEG_EN` defined:
  - Code 21 in FETCH with `ndig==0` and `neg==0` sets `neg` and advances `index`. This is unary minus at expression start or after an operator.
  - A second consecutive `-` → ERROR.
  - Magnitude is limited to 2^WIDTH−1; the emitted value is the WIDTH-bit two's complement.
- Undefined: `neg` is tied to 0, and code 21 with `ndig==0` → ERROR.

## Test plan
- ROM 1,5,22,1,0,20,9,10, `tok_ready=1` → tokens (0,15), (1,*), (0,10), (1,+), (0,9), (2); `done=1`; `err=0`.
- Same ROM with `tok_ready` low 3 cycles per token → identical stream; fields stable through every stall; `index` frozen.
- ROM 6,5,5,3,5,10 with WIDTH=16 → operand 65535 then end. ROM 6,5,5,3,6,10 → ERROR at `index=4`, no token emitted.
- ROM 20,1,10 → ERROR at `index=0`. ROM 1,20,10 → operand 1, op +, then ERROR. ROM 1,30,10 → ERROR.
- ROM 21,7,22,21,2,10 → with `TOKEN_SCANNER_NEG_EN`: (0,−7 = 0xFFF9), (1,*), (0,0xFFFE), (2). Without it: ERROR at `index=0`.
- `rst` pulsed while waiting in EMIT_NUM → all outputs at reset values immediately; a following `start` rescans from `index=0`.
